// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline definitions: per-boundary payload widths, payload struct
// layouts, and the skid-stage state encoding. The skid stage itself only
// uses the state encoding and the default width, so it stays payload-agnostic.
package pipe_skid_stage_pkg;

  localparam int IF_ID_WIDTH  = 64;
  localparam int ID_EX_WIDTH  = 128;
  localparam int EX_MEM_WIDTH = 104;
  localparam int MEM_WB_WIDTH = 72;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [2:0]  funct3;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [2:0]  wb_sel;
  } mem_wb_t;

  // Skid-stage state encoding; 2'b11 is unused and treated as illegal.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  function automatic logic [1:0] state_count(input logic [1:0] st);
    case (st)
      ST_BUSY: state_count = 2'd1;
      ST_FULL: state_count = 2'd2;
      default: state_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer placed at a pipeline boundary in place of a plain
// enable flop. All handshake outputs come straight from registers, so there
// is no combinational path from i_ready to o_ready.
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset      synchronous, active-low reset
//   i_valid      upstream payload valid
//   o_ready      stage can accept a payload this cycle
//   i_data       upstream payload
//   o_valid      downstream payload valid
//   i_ready      downstream accepts payload this cycle
//   o_data       downstream payload (main register)
//   i_flush      discard all held entries (redirect)
//   o_count      held entries, 0..2
//   o_stall_cnt  saturating count of cycles with o_valid=1 and i_ready=0
//
// state | meaning
// ------+-----------------------------------
// EMPTY | no entries held
// BUSY  | main register holds a payload
// FULL  | main and skid registers both held
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int                    DATA_WIDTH = IF_ID_WIDTH,
  parameter logic [DATA_WIDTH-1:0] BUBBLE     = '0,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_flush,
  output logic [1:0]            o_count,
  output logic [CNT_WIDTH-1:0]  o_stall_cnt
);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [DATA_WIDTH-1:0] w_main_nxt;
  logic [DATA_WIDTH-1:0] w_skid_nxt;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;
  logic                  w_in_fire;
  logic                  w_out_fire;

  assign o_valid     = (r_state != ST_EMPTY);
  assign o_ready     = (r_state != ST_FULL);
  assign o_data      = r_main;
  assign o_count     = state_count(r_state);
  assign o_stall_cnt = r_stall_cnt;

  assign w_in_fire  = i_valid & o_ready;
  assign w_out_fire = o_valid & i_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (i_flush) begin
      // Redirect wins over everything, including a same-cycle accept.
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = BUBBLE;
      w_skid_nxt  = BUBBLE;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_BUSY;
            w_main_nxt  = i_data;
          end
        end
        ST_BUSY: begin
          if (w_in_fire && !w_out_fire) begin
            w_state_nxt = ST_FULL;
            w_skid_nxt  = i_data;
          end else if (!w_in_fire && w_out_fire) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = BUBBLE;
          end else if (w_in_fire && w_out_fire) begin
            w_main_nxt  = i_data;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_state_nxt = ST_BUSY;
            w_main_nxt  = r_skid;
            w_skid_nxt  = BUBBLE;
          end
        end
        default: begin
          // Unused encoding: fall back to a clean empty stage.
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = BUBBLE;
          w_skid_nxt  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= ST_EMPTY;
      r_main  <= BUBBLE;
      r_skid  <= BUBBLE;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // Stall statistics survive flushes; only reset clears them.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_stall_cnt <= '0;
    end else if (o_valid && !i_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  localparam logic [63:0] TB_BUBBLE = 64'hBBBB_0000_0000_BBBB;

  logic        i_clk;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [63:0] i_data;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_data;
  logic        i_flush;
  logic [1:0]  o_count;
  logic [3:0]  o_stall_cnt;

  pipe_skid_stage #(
    .DATA_WIDTH(64),
    .BUBBLE    (TB_BUBBLE),
    .CNT_WIDTH (4)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .i_flush    (i_flush),
    .o_count    (o_count),
    .o_stall_cnt(o_stall_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: payloads pushed on accept, popped when the DUT emits them.
  logic [63:0] mq[$];
  logic [3:0]  m_stall;

  typedef struct {
    logic        rst;
    logic        v;
    logic [63:0] d;
    logic        rdy;
    logic        fl;
    logic        ev;
    logic        er;
    logic [1:0]  ec;
    logic [63:0] ed;
    logic [3:0]  es;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic rst, v, input logic [63:0] d,
                              input logic rdy, fl, ev, er, input logic [1:0] ec,
                              input logic [63:0] ed, input logic [3:0] es);
    vec_t t;
    t.rst = rst; t.v = v; t.d = d; t.rdy = rdy; t.fl = fl;
    t.ev = ev; t.er = er; t.ec = ec; t.ed = ed; t.es = es;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic [63:0] d,
                      input logic rdy, input logic fl);
    bit inf, outf, stl;
    @(negedge i_clk);
    i_reset = rst; i_valid = v; i_data = d; i_ready = rdy; i_flush = fl;
    #1;
    inf  = v && (mq.size() < 2);
    outf = (mq.size() > 0) && rdy;
    stl  = (mq.size() > 0) && !rdy;
    if (outf) chk("sb_out_data", o_data, mq[0]);
    @(posedge i_clk);
    if (!rst) begin
      mq.delete();
      m_stall = 4'd0;
    end else begin
      if (stl && m_stall != 4'hF) m_stall = m_stall + 4'd1;
      if (fl) mq.delete();
      else begin
        if (outf) void'(mq.pop_front());
        if (inf) mq.push_back(d);
      end
    end
    #1;
    chk("m_valid", o_valid, (mq.size() > 0));
    chk("m_ready", o_ready, (mq.size() < 2));
    chk("m_count", o_count, mq.size());
    chk("m_data",  o_data, (mq.size() > 0) ? mq[0] : TB_BUBBLE);
    chk("m_stall", o_stall_cnt, m_stall);
  endtask

  initial begin
    i_reset = 1'b0; i_valid = 1'b0; i_data = '0; i_ready = 1'b0; i_flush = 1'b0;
    m_stall = 4'd0;

    //              rst v  d      rdy fl   ev er ec  ed         es
    tbl[0]  = mk(0, 1, 64'hA, 1, 0,   0, 1, 0, TB_BUBBLE, 0);
    tbl[1]  = mk(0, 1, 64'hA, 1, 0,   0, 1, 0, TB_BUBBLE, 0);
    tbl[2]  = mk(1, 1, 64'd1, 1, 0,   1, 1, 1, 64'd1,     0);
    tbl[3]  = mk(1, 1, 64'd2, 1, 0,   1, 1, 1, 64'd2,     0);
    tbl[4]  = mk(1, 1, 64'd3, 1, 0,   1, 1, 1, 64'd3,     0);
    tbl[5]  = mk(1, 1, 64'd4, 1, 0,   1, 1, 1, 64'd4,     0);
    tbl[6]  = mk(1, 0, 64'd0, 1, 0,   0, 1, 0, TB_BUBBLE, 0);
    tbl[7]  = mk(1, 1, 64'd5, 0, 0,   1, 1, 1, 64'd5,     0);
    tbl[8]  = mk(1, 1, 64'd6, 0, 0,   1, 0, 2, 64'd5,     1);
    tbl[9]  = mk(1, 1, 64'd7, 0, 0,   1, 0, 2, 64'd5,     2);
    tbl[10] = mk(1, 1, 64'd7, 0, 0,   1, 0, 2, 64'd5,     3);
    tbl[11] = mk(1, 1, 64'd7, 1, 0,   1, 1, 1, 64'd6,     3);
    tbl[12] = mk(1, 1, 64'd7, 1, 0,   1, 1, 1, 64'd7,     3);
    tbl[13] = mk(1, 0, 64'd0, 1, 0,   0, 1, 0, TB_BUBBLE, 3);
    tbl[14] = mk(1, 1, 64'd8, 0, 0,   1, 1, 1, 64'd8,     3);
    tbl[15] = mk(1, 1, 64'd9, 0, 0,   1, 0, 2, 64'd8,     4);
    tbl[16] = mk(1, 1, 64'd10, 1, 1,  0, 1, 0, TB_BUBBLE, 4);
    tbl[17] = mk(1, 0, 64'd0, 1, 0,   0, 1, 0, TB_BUBBLE, 4);
    tbl[18] = mk(1, 1, 64'd11, 0, 0,  1, 1, 1, 64'd11,    4);
    tbl[19] = mk(1, 1, 64'd12, 1, 0,  1, 1, 1, 64'd12,    4);
    tbl[20] = mk(1, 0, 64'd0, 1, 0,   0, 1, 0, TB_BUBBLE, 4);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].rdy, tbl[i].fl);
      chk($sformatf("tbl%0d_valid", i), o_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_ready", i), o_ready, tbl[i].er);
      chk($sformatf("tbl%0d_count", i), o_count, tbl[i].ec);
      chk($sformatf("tbl%0d_data", i), o_data, tbl[i].ed);
      chk($sformatf("tbl%0d_stall", i), o_stall_cnt, tbl[i].es);
    end

    // Reset while FULL drops both entries and clears the stall counter.
    step(1, 1, 64'd13, 0, 0);
    step(1, 1, 64'd14, 0, 0);
    chk("rstfull_pre_count", o_count, 2'd2);
    step(0, 1, 64'd99, 0, 0);
    chk("rstfull_count", o_count, 2'd0);
    chk("rstfull_valid", o_valid, 1'b0);
    chk("rstfull_stall", o_stall_cnt, 4'd0);
    step(1, 0, 64'd0, 1, 0);
    chk("rstfull_after_valid", o_valid, 1'b0);

    // Stall counter saturation.
    step(1, 1, 64'd15, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 64'd0, 0, 0);
    chk("sat_stall", o_stall_cnt, 4'hF);
    step(1, 0, 64'd0, 0, 0);
    chk("sat_stall_hold", o_stall_cnt, 4'hF);
    step(1, 1, 64'd0, 0, 1);
    chk("sat_stall_flush", o_stall_cnt, 4'hF);
    step(1, 0, 64'd0, 1, 0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) != 0),
           1'($urandom_range(0, 1)),
           {$urandom, $urandom},
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 24) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, payload width in bits (IF/ID stage = 64: pc + inst).
REQ-002 SHALL have parameter BUBBLE, DATA_WIDTH bits, default all-zero, payload value held in empty/flushed entries.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, width of stall counter.
REQ-004 i_clk  input  1  clock, all state updates on rising edge.
REQ-005 i_reset  input  1  synchronous, active-low reset.
REQ-006 i_valid  input  1  upstream payload valid.
REQ-007 o_ready  output  1  stage can accept payload this cycle.
REQ-008 i_data  input  DATA_WIDTH  upstream payload.
REQ-009 o_valid  output  1  downstream payload valid.
REQ-010 i_ready  input  1  downstream accepts payload this cycle.
REQ-011 o_data  output  DATA_WIDTH  downstream payload.
REQ-012 i_flush  input  1  discard all held entries (branch/jump redirect).
REQ-013 o_count  output  2  held entries, 0..2.
REQ-014 o_stall_cnt  output  CNT_WIDTH  cycles with o_valid=1 and i_ready=0.

Function
REQ-015 SHALL define in_fire = i_valid & o_ready, out_fire = o_valid & i_ready.
REQ-016 SHALL implement FSM states EMPTY (0 entries), BUSY (main only), FULL (main + skid).
REQ-017 Outputs SHALL be registered-state-derived only: o_valid = (state != EMPTY), o_ready = (state != FULL), o_data = main register; no combinational path from i_ready to o_ready.
REQ-018 EMPTY: in_fire -> BUSY, main <= i_data.
REQ-019 BUSY: in_fire & !out_fire -> FULL, skid <= i_data; !in_fire & out_fire -> EMPTY, main <= BUBBLE; in_fire & out_fire -> BUSY, main <= i_data; neither -> hold.
REQ-020 FULL: out_fire -> BUSY, main <= skid, skid <= BUBBLE; else hold; no input accepted.
REQ-021 Latency SHALL be 1 cycle: payload accepted at edge N visible on o_data after edge N with o_valid=1.
REQ-022 Throughput SHALL be 1 payload/cycle while i_ready=1 continuously.
REQ-023 Payload order SHALL be preserved; no payload duplicated or lost except by flush.
REQ-024 i_flush=1 SHALL take priority over all events: next state EMPTY, main and skid <= BUBBLE, any same-cycle in_fire payload dropped.
REQ-025 o_count SHALL equal 0/1/2 for EMPTY/BUSY/FULL.
REQ-026 o_stall_cnt SHALL increment by 1 each cycle with o_valid=1 & i_ready=0, saturate at all-ones, not cleared by flush.
REQ-027 Illegal state encoding SHALL recover to EMPTY on next edge.

Reset
REQ-028 i_reset=0 at an edge SHALL set state EMPTY, main and skid = BUBBLE, o_stall_cnt = 0, regardless of other inputs.
REQ-029 During reset: o_valid=0, o_ready=1, o_data=BUBBLE, o_count=0 after first reset edge.
REQ-030 Reset mid-operation (FULL) SHALL discard both entries with no output fire.

Structure
REQ-031 Stage widths (IF_ID_WIDTH=64, ID_EX, EX_MEM, MEM_WB) and stage payload struct typedefs SHALL live in package_param; this block stays payload-agnostic.
REQ-032 SHALL be one module, no sub-modules; stall counter inline.
REQ-033 SHALL be instantiated once per pipeline boundary, replacing the plain enable flop.

Verification
REQ-034 Reset: i_reset=0 two cycles with i_valid=1, i_data=64'hA -> o_valid=0, o_ready=1, o_count=0, o_stall_cnt=0, o_data=BUBBLE.
REQ-035 Streaming: i_ready=1, push 1,2,3,4 back-to-back -> o_data 1,2,3,4 on consecutive cycles, one cycle after each accept, o_count=1.
REQ-036 Backpressure: i_ready=0, push 5,6,7 -> 5,6 accepted, o_ready=0 after 6, 7 held upstream, o_count=2, o_stall_cnt increments per cycle; release i_ready -> outputs 5,6,7 in order.
REQ-037 Flush: state FULL (8,9), i_flush=1 with i_valid=1, i_data=10 -> next cycle o_valid=0, o_count=0, 10 never appears; o_stall_cnt unchanged by flush.
REQ-038 Simultaneous: BUSY holding 11, i_valid=1 data 12, i_ready=1 -> next cycle o_data=12, o_count=1.
REQ-039 Saturation: CNT_WIDTH=4, hold i_ready=0 with o_valid=1 for 20 cycles -> o_stall_cnt=15, stays 15.
